// File: rtl/ysyx_22041207_cache_refill.sv
// Blocking single-request cache front end: lookup, miss refill, write-through store.
// Optional macro YSYX_22041207_REFILL_UNCACHED_EN: addr[63:31]==0 bypasses the cache.
module ysyx_22041207_cache_refill (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req_valid,
    output logic        cpu_req_ready,
    input  logic        cpu_req_wen,
    input  logic [63:0] cpu_req_addr,
    input  logic [63:0] cpu_req_wdata,
    input  logic [7:0]  cpu_req_wmask,
    output logic        cpu_resp_valid,
    output logic [63:0] cpu_resp_rdata,
    output logic [63:0] cache_read_addr,
    input  logic        cache_read_hit,
    input  logic [63:0] cache_read_data,
    output logic        cache_update_data,
    output logic [63:0] cache_update_address,
    output logic [63:0] cache_actual_data,
    output logic        cache_w_update,
    output logic [63:0] cache_w_address,
    output logic [63:0] cache_w_data,
    output logic [7:0]  cache_w_mask,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_wen,
    output logic [63:0] mem_req_addr,
    output logic [63:0] mem_req_wdata,
    output logic [7:0]  mem_req_wmask,
    input  logic        mem_resp_valid,
    input  logic [63:0] mem_resp_rdata
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_MEM_REQ, S_MEM_WAIT, S_RESP
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [63:0] r_addr;
    logic        r_wen;
    logic [63:0] r_wdata;
    logic [7:0]  r_wmask;
    logic [63:0] r_rdata;
    logic        w_uncached;
    logic        w_hit;

`ifdef YSYX_22041207_REFILL_UNCACHED_EN
    assign w_uncached = (r_addr[63:31] == 33'd0);
`else
    assign w_uncached = 1'b0;
`endif

    // An uncached access never trusts the tag compare
    assign w_hit = cache_read_hit & ~w_uncached;

    // State register; reset abandons any in-flight memory transaction
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (cpu_req_valid) w_next = S_LOOKUP;
            S_LOOKUP:   w_next = (!r_wen && w_hit) ? S_RESP : S_MEM_REQ;
            S_MEM_REQ:  if (mem_req_ready) w_next = S_MEM_WAIT;
            S_MEM_WAIT: if (mem_resp_valid) w_next = S_RESP;
            S_RESP:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // Request latch and load-data capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= 64'd0;
            r_wen   <= 1'b0;
            r_wdata <= 64'd0;
            r_wmask <= 8'd0;
            r_rdata <= 64'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cpu_req_valid) begin
                        r_addr  <= cpu_req_addr;
                        r_wen   <= cpu_req_wen;
                        r_wdata <= cpu_req_wdata;
                        r_wmask <= cpu_req_wmask;
                        r_rdata <= 64'd0;
                    end
                end
                S_LOOKUP: begin
                    if (!r_wen && w_hit) r_rdata <= cache_read_data;
                end
                S_MEM_WAIT: begin
                    if (mem_resp_valid && !r_wen) r_rdata <= mem_resp_rdata;
                end
                default: ;
            endcase
        end
    end

    assign cache_read_addr      = r_addr;
    assign cache_update_address = r_addr;
    assign cache_w_address      = r_addr;
    assign cache_actual_data    = mem_resp_rdata;
    assign cache_w_data         = r_wdata;
    assign cache_w_mask         = r_wmask;
    assign mem_req_wen          = r_wen;
    assign mem_req_addr         = {r_addr[63:3], 3'b000};
    assign mem_req_wdata        = r_wdata;
    assign mem_req_wmask        = r_wen ? r_wmask : 8'h00;

    // Per-state strobes, all held low while reset is asserted
    always_comb begin
        cpu_req_ready     = 1'b0;
        cpu_resp_valid    = 1'b0;
        cpu_resp_rdata    = 64'd0;
        mem_req_valid     = 1'b0;
        cache_w_update    = 1'b0;
        cache_update_data = 1'b0;
        if (!rst) begin
            case (r_state)
                S_IDLE:     cpu_req_ready = 1'b1;
                S_LOOKUP:   cache_w_update = r_wen & w_hit;
                S_MEM_REQ:  mem_req_valid = 1'b1;
                S_MEM_WAIT: cache_update_data = mem_resp_valid & ~r_wen
                                                & ~w_uncached;
                S_RESP: begin
                    cpu_resp_valid = 1'b1;
                    cpu_resp_rdata = r_rdata;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22041207_cache_refill.sv
// Directed bench for ysyx_22041207_cache_refill with a response scoreboard.
// Honours YSYX_22041207_REFILL_UNCACHED_EN for the uncached-region case.
module tb_ysyx_22041207_cache_refill;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req_valid;
    logic        cpu_req_ready;
    logic        cpu_req_wen;
    logic [63:0] cpu_req_addr;
    logic [63:0] cpu_req_wdata;
    logic [7:0]  cpu_req_wmask;
    logic        cpu_resp_valid;
    logic [63:0] cpu_resp_rdata;
    logic [63:0] cache_read_addr;
    logic        cache_read_hit;
    logic [63:0] cache_read_data;
    logic        cache_update_data;
    logic [63:0] cache_update_address;
    logic [63:0] cache_actual_data;
    logic        cache_w_update;
    logic [63:0] cache_w_address;
    logic [63:0] cache_w_data;
    logic [7:0]  cache_w_mask;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_wen;
    logic [63:0] mem_req_addr;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_rdata;

    ysyx_22041207_cache_refill dut (
        .clk                  (clk),
        .rst                  (rst),
        .cpu_req_valid        (cpu_req_valid),
        .cpu_req_ready        (cpu_req_ready),
        .cpu_req_wen          (cpu_req_wen),
        .cpu_req_addr         (cpu_req_addr),
        .cpu_req_wdata        (cpu_req_wdata),
        .cpu_req_wmask        (cpu_req_wmask),
        .cpu_resp_valid       (cpu_resp_valid),
        .cpu_resp_rdata       (cpu_resp_rdata),
        .cache_read_addr      (cache_read_addr),
        .cache_read_hit       (cache_read_hit),
        .cache_read_data      (cache_read_data),
        .cache_update_data    (cache_update_data),
        .cache_update_address (cache_update_address),
        .cache_actual_data    (cache_actual_data),
        .cache_w_update       (cache_w_update),
        .cache_w_address      (cache_w_address),
        .cache_w_data         (cache_w_data),
        .cache_w_mask         (cache_w_mask),
        .mem_req_valid        (mem_req_valid),
        .mem_req_ready        (mem_req_ready),
        .mem_req_wen          (mem_req_wen),
        .mem_req_addr         (mem_req_addr),
        .mem_req_wdata        (mem_req_wdata),
        .mem_req_wmask        (mem_req_wmask),
        .mem_resp_valid       (mem_resp_valid),
        .mem_resp_rdata       (mem_resp_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] d;
        int          c;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          resp_cnt;
    int          mreq_cnt;
    int          upd_cnt;
    int          wup_cnt;
    logic [63:0] upd_data;
    logic [63:0] upd_addr;
    logic [63:0] w_data_s;
    logic [7:0]  w_mask_s;
    logic [63:0] e_maddr;
    logic        e_mwen;
    logic [63:0] e_mwdata;
    logic [7:0]  e_mwmask;

    task automatic chk(input string tag, input logic [63:0] o,
                       input logic [63:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Sample this cycle's outputs after the inputs have settled
    task automatic obs();
        exp_t e;
        #1;
        if (cache_update_data || cache_w_update)
            chk("strobe_excl", 64'(cache_update_data & cache_w_update), 0);
        if (cache_update_data) begin
            upd_cnt++;
            upd_data = cache_actual_data;
            upd_addr = cache_update_address;
        end
        if (cache_w_update) begin
            wup_cnt++;
            w_data_s = cache_w_data;
            w_mask_s = cache_w_mask;
        end
        if (mem_req_valid) begin
            mreq_cnt++;
            chk("mem_addr", mem_req_addr, e_maddr);
            chk("mem_wen", 64'(mem_req_wen), 64'(e_mwen));
            chk("mem_wdata", mem_req_wdata, e_mwdata);
            chk("mem_wmask", 64'(mem_req_wmask), 64'(e_mwmask));
        end
        if (cpu_resp_valid) begin
            resp_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_resp", 64'(cpu_resp_valid), 0);
            end else begin
                e = sb.pop_front();
                chk("resp_rdata", cpu_resp_rdata, e.d);
                chk("resp_cycle", 64'(cyc), 64'(e.c));
            end
        end
    endtask

    task automatic clr_cnt();
        resp_cnt = 0;
        mreq_cnt = 0;
        upd_cnt  = 0;
        wup_cnt  = 0;
        upd_data = '0;
        upd_addr = '0;
        w_data_s = '0;
        w_mask_s = '0;
    endtask

    task automatic run_txn(
        input string       tag,
        input logic        wen,
        input logic [63:0] addr,
        input logic [63:0] wdata,
        input logic [7:0]  wmask,
        input logic        hit,
        input logic [63:0] hdata,
        input int          rw,
        input int          rn,
        input logic [63:0] mdata,
        input logic [63:0] exp_rdata,
        input int          exp_lat,
        input int          exp_mreq,
        input int          exp_upd,
        input int          exp_wup,
        input logic [63:0] exp_maddr,
        input logic [7:0]  exp_mwmask
    );
        exp_t e;
        int   t0;
        int   mseen;
        int   widx;
        bit   hs_done;
        bit   hs_now;
        clr_cnt();
        e_maddr  = exp_maddr;
        e_mwen   = wen;
        e_mwdata = wdata;
        e_mwmask = exp_mwmask;
        cycle();
        cpu_req_valid   = 1'b1;
        cpu_req_wen     = wen;
        cpu_req_addr    = addr;
        cpu_req_wdata   = wdata;
        cpu_req_wmask   = wmask;
        cache_read_hit  = hit;
        cache_read_data = hdata;
        mem_resp_rdata  = mdata;
        mem_req_ready   = 1'b0;
        mem_resp_valid  = 1'b0;
        t0 = cyc;
        e.d = exp_rdata;
        e.c = t0 + exp_lat;
        sb.push_back(e);
        obs();
        chk({tag, "_accept_ready"}, 64'(cpu_req_ready), 1);
        mseen   = 0;
        widx    = 0;
        hs_done = 0;
        for (int i = 0; i < 40 && resp_cnt == 0; i++) begin
            cycle();
            cpu_req_valid  = 1'b0;
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            hs_now = 0;
            if (hs_done) begin
                if (widx == rn) mem_resp_valid = 1'b1;
                widx++;
            end
            if (mem_req_valid) begin
                mem_req_ready = (mseen >= rw);
                hs_now = mem_req_ready;
                mseen++;
            end
            obs();
            if (hs_now) hs_done = 1;
        end
        chk({tag, "_resp_seen"}, 64'(resp_cnt), 1);
        cycle();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        obs();
        chk({tag, "_ready_back"}, 64'(cpu_req_ready), 1);
        chk({tag, "_resp_once"}, 64'(resp_cnt), 1);
        chk({tag, "_mreq_cycles"}, 64'(mreq_cnt), 64'(exp_mreq));
        chk({tag, "_upd_cnt"}, 64'(upd_cnt), 64'(exp_upd));
        chk({tag, "_wup_cnt"}, 64'(wup_cnt), 64'(exp_wup));
        if (exp_upd != 0) begin
            chk({tag, "_upd_data"}, upd_data, mdata);
            chk({tag, "_upd_addr"}, upd_addr, addr);
        end
        if (exp_wup != 0) begin
            chk({tag, "_w_data"}, w_data_s, wdata);
            chk({tag, "_w_mask"}, 64'(w_mask_s), 64'(wmask));
        end
    endtask

    initial begin
        rst             = 1'b1;
        cpu_req_valid   = 1'b0;
        cpu_req_wen     = 1'b0;
        cpu_req_addr    = '0;
        cpu_req_wdata   = '0;
        cpu_req_wmask   = '0;
        cache_read_hit  = 1'b0;
        cache_read_data = '0;
        mem_req_ready   = 1'b0;
        mem_resp_valid  = 1'b0;
        mem_resp_rdata  = '0;
        clr_cnt();

        cycle();
        cycle();
        obs();
        chk("rst_resp_valid", 64'(cpu_resp_valid), 0);
        chk("rst_mem_valid", 64'(mem_req_valid), 0);
        chk("rst_upd", 64'(cache_update_data), 0);
        chk("rst_wup", 64'(cache_w_update), 0);
        chk("rst_rdata", cpu_resp_rdata, 0);
        chk("rst_addr", cache_read_addr, 0);
        rst = 1'b0;
        cycle();
        obs();
        chk("post_rst_ready", 64'(cpu_req_ready), 1);

        run_txn("hit_load", 0, 64'h8000_0010, 0, 8'h00, 1,
                64'h1122_3344_5566_7788, 0, 0, 64'h0,
                64'h1122_3344_5566_7788, 2, 0, 0, 0,
                64'h8000_0010, 8'h00);

        run_txn("miss_load", 0, 64'h8000_0018, 0, 8'h00, 0, 64'h0,
                0, 3, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 7, 1, 1, 0,
                64'h8000_0018, 8'h00);

        run_txn("store_hit", 1, 64'h8000_0008, 64'hAABB_CCDD, 8'h0F,
                1, 64'h9999, 0, 1, 64'h5555_5555, 64'h0, 5, 1, 0, 1,
                64'h8000_0008, 8'h0F);

        run_txn("store_stall", 1, 64'h8000_0105, 64'h0123_4567_89AB_CDEF,
                8'hF0, 0, 64'h0, 4, 0, 64'h77, 64'h0, 8, 5, 0, 0,
                64'h8000_0100, 8'hF0);

        run_txn("miss_unalign", 0, 64'h8000_0033, 0, 8'h00, 0, 64'h0,
                2, 1, 64'hCAFE_F00D_1234_5678, 64'hCAFE_F00D_1234_5678,
                7, 3, 1, 0, 64'h8000_0030, 8'h00);

        clr_cnt();
        cycle();
        mem_resp_valid = 1'b1;
        mem_req_ready  = 1'b1;
        obs();
        cycle();
        obs();
        mem_resp_valid = 1'b0;
        mem_req_ready  = 1'b0;
        chk("stray_upd", 64'(upd_cnt), 0);
        chk("stray_resp", 64'(resp_cnt), 0);
        chk("stray_ready", 64'(cpu_req_ready), 1);

        clr_cnt();
        e_maddr  = 64'h8000_0020;
        e_mwen   = 1'b0;
        e_mwdata = 64'h0;
        e_mwmask = 8'h00;
        cycle();
        cpu_req_valid  = 1'b1;
        cpu_req_wen    = 1'b0;
        cpu_req_addr   = 64'h8000_0020;
        cpu_req_wdata  = 64'h0;
        cache_read_hit = 1'b0;
        mem_resp_rdata = 64'h4242;
        obs();
        cycle();
        cpu_req_valid = 1'b0;
        obs();
        cycle();
        mem_req_ready = 1'b1;
        obs();
        chk("abort_mreq", 64'(mem_req_valid), 1);
        cycle();
        mem_req_ready = 1'b0;
        rst = 1'b1;
        obs();
        chk("abort_rst_mreq", 64'(mem_req_valid), 0);
        cycle();
        rst = 1'b0;
        mem_resp_valid = 1'b1;
        obs();
        chk("abort_upd", 64'(cache_update_data), 0);
        chk("abort_idle", 64'(cpu_req_ready), 1);
        cycle();
        mem_resp_valid = 1'b0;
        obs();
        cycle();
        obs();
        chk("abort_no_resp", 64'(resp_cnt), 0);
        chk("abort_no_upd", 64'(upd_cnt), 0);
        chk("abort_addr_clr", cache_read_addr, 0);

`ifdef YSYX_22041207_REFILL_UNCACHED_EN
        run_txn("uncached_load", 0, 64'h1000_0000, 0, 8'h00, 1,
                64'h1111, 0, 2, 64'hFEED_FACE, 64'hFEED_FACE, 6, 1, 0, 0,
                64'h1000_0000, 8'h00);
        run_txn("uncached_store", 1, 64'h1000_0008, 64'h33, 8'h01, 1,
                64'h0, 0, 0, 64'h0, 64'h0, 4, 1, 0, 0,
                64'h1000_0008, 8'h01);
`else
        run_txn("low_hit_load", 0, 64'h1000_0000, 0, 8'h00, 1,
                64'h1111, 0, 2, 64'hFEED_FACE, 64'h1111, 2, 0, 0, 0,
                64'h1000_0000, 8'h00);
`endif

        chk("sb_empty", 64'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
